// File: rtl/ray_sweep_scheduler.sv
// Per-pixel ray sweep: issues sphere indices to the shared read port, tracks the
// nearest hit through a READ_LAT-deep tag pipe, and hands the result off with valid/ready.
module ray_sweep_scheduler #(
  parameter int unsigned N_SPHERES = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned DIST_W    = 64,
  parameter int unsigned READ_LAT  = 2,
  parameter logic [DIST_W-1:0] FAR_DIST = 64'hefffffffffffffff
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  output logic [IDX_W-1:0]  Read_Index,
  input  logic              Collision,
  input  logic [DIST_W-1:0] Curr_Dist,
  output logic [DIST_W-1:0] Best_Dist,
  output logic [IDX_W-1:0]  Best_Index,
  output logic              Hit_Any,
  output logic              Busy,
  output logic              Write_Pixel,
  input  logic              Write_Ready,
  output logic              Pixel_Adv
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPHERES - 1);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                issue_q, issue_d;
  logic [READ_LAT-1:0]             vld_q, vld_d;
  logic [READ_LAT-1:0][IDX_W-1:0]  tag_q, tag_d;
  logic [DIST_W-1:0]               best_dist_q, best_dist_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic                            hit_q, hit_d;
  logic                            adv_q, adv_d;
  logic                            push;
  logic                            drain_done;
  logic                            out_vld;
  logic [IDX_W-1:0]                out_tag;

  assign out_vld = vld_q[READ_LAT-1];
  assign out_tag = tag_q[READ_LAT-1];

  // Only the output stage may still be occupied: its result is consumed this cycle.
  always_comb begin
    drain_done = 1'b1;
    for (int unsigned i = 0; i < READ_LAT - 1; i++) begin
      if (vld_q[i]) drain_done = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    push    = 1'b0;
    if (Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d = SWEEP;
            issue_d = '0;
          end
        end
        SWEEP: begin
          push = 1'b1;
          if (issue_q == LAST_IDX) state_d = DRAIN;
          else                     issue_d = issue_q + 1'b1;
        end
        DRAIN: begin
          if (drain_done) state_d = WRITE;
        end
        WRITE: begin
          if (Write_Ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = push;
    tag_d[0] = issue_q;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (Abort) vld_d = '0;
  end

  // Strict less-than: ties keep the earlier index and FAR_DIST can never win.
  always_comb begin
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    hit_d       = hit_q;
    if (!Abort) begin
      if (state_q == IDLE && Start) begin
        best_dist_d = FAR_DIST;
        best_idx_d  = '0;
        hit_d       = 1'b0;
      end else if (out_vld && Collision && (Curr_Dist < best_dist_q)) begin
        best_dist_d = Curr_Dist;
        best_idx_d  = out_tag;
        hit_d       = 1'b1;
      end
    end
  end

  assign adv_d = !Abort && (state_q == WRITE) && Write_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      vld_q       <= '0;
      tag_q       <= '0;
      best_dist_q <= FAR_DIST;
      best_idx_q  <= '0;
      hit_q       <= 1'b0;
      adv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      hit_q       <= hit_d;
      adv_q       <= adv_d;
    end
  end

  assign Read_Index  = (state_q == IDLE) ? '0 : issue_q;
  assign Best_Dist   = best_dist_q;
  assign Best_Index  = best_idx_q;
  assign Hit_Any     = hit_q;
  assign Busy        = (state_q != IDLE);
  assign Write_Pixel = (state_q == WRITE);
  assign Pixel_Adv   = adv_q;

endmodule

// File: tb/tb_ray_sweep_scheduler.sv
// Directed bench for ray_sweep_scheduler with a READ_LAT=2 behavioural datapath.
module tb_ray_sweep_scheduler;

  localparam logic [63:0] FAR = 64'hefffffffffffffff;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Abort;
  logic [1:0]  Read_Index;
  logic        Collision;
  logic [63:0] Curr_Dist;
  logic [63:0] Best_Dist;
  logic [1:0]  Best_Index;
  logic        Hit_Any;
  logic        Busy;
  logic        Write_Pixel;
  logic        Write_Ready;
  logic        Pixel_Adv;

  int checks = 0;
  int errors = 0;

  logic [3:0]  tbl_hit;
  logic [63:0] tbl_dist [4];
  logic [1:0]  rd_d1, rd_d2;

  ray_sweep_scheduler #(
    .N_SPHERES(4),
    .IDX_W(2),
    .DIST_W(64),
    .READ_LAT(2),
    .FAR_DIST(FAR)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Start(Start),
    .Abort(Abort),
    .Read_Index(Read_Index),
    .Collision(Collision),
    .Curr_Dist(Curr_Dist),
    .Best_Dist(Best_Dist),
    .Best_Index(Best_Index),
    .Hit_Any(Hit_Any),
    .Busy(Busy),
    .Write_Pixel(Write_Pixel),
    .Write_Ready(Write_Ready),
    .Pixel_Adv(Pixel_Adv)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sphere datapath model: result for the index driven two cycles earlier.
  always @(posedge Clk) begin
    rd_d1 <= Read_Index;
    rd_d2 <= rd_d1;
  end
  assign Collision = tbl_hit[rd_d2];
  assign Curr_Dist = tbl_dist[rd_d2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic set_tbl(input logic [3:0] h, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3);
    tbl_hit     = h;
    tbl_dist[0] = d0;
    tbl_dist[1] = d1;
    tbl_dist[2] = d2;
    tbl_dist[3] = d3;
  endtask

  // Pulse Start, then wait (bounded) for Write_Pixel; reports the cycle it appeared.
  task automatic sweep_to_write(input string tag, output int cyc);
    Start = 1'b1;
    step();
    Start = 1'b0;
    cyc = 0;
    while (!Write_Pixel && cyc < 30) begin
      step();
      cyc++;
    end
    chk({tag, "_write_cycle"}, 64'(cyc), 64'd6);
  endtask

  task automatic accept(input string tag);
    Write_Ready = 1'b1;
    step();
    Write_Ready = 1'b0;
    chk({tag, "_adv"}, 64'(Pixel_Adv), 64'd1);
    chk({tag, "_idle"}, 64'(Busy), 64'd0);
    step();
    chk({tag, "_adv_once"}, 64'(Pixel_Adv), 64'd0);
  endtask

  initial begin
    int cyc;
    int t;
    int npulse;
    int pt [3];

    Reset_n     = 1'b0;
    Start       = 1'b0;
    Abort       = 1'b0;
    Write_Ready = 1'b0;
    set_tbl(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (2) step();

    chk("rst_read_index", 64'(Read_Index), 64'd0);
    chk("rst_best_dist", Best_Dist, FAR);
    chk("rst_best_index", 64'(Best_Index), 64'd0);
    chk("rst_hit_any", 64'(Hit_Any), 64'd0);
    chk("rst_write_pixel", 64'(Write_Pixel), 64'd0);
    chk("rst_pixel_adv", 64'(Pixel_Adv), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    Reset_n = 1'b1;
    step();

    // Pixel 1: single hit on index 2, then Write_Ready held low for five cycles.
    set_tbl(4'b0100, 64'h0, 64'h0, 64'h100, 64'h0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("t1_busy", 64'(Busy), 64'd1);
    chk("t1_ri0", 64'(Read_Index), 64'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t1_ri_seq", 64'(Read_Index), 64'(k));
    end
    step();
    chk("t1_ri_hold", 64'(Read_Index), 64'd3);
    chk("t1_wp_c4", 64'(Write_Pixel), 64'd0);
    step();
    chk("t1_wp_c5", 64'(Write_Pixel), 64'd0);
    step();
    chk("t1_wp_c6", 64'(Write_Pixel), 64'd1);
    chk("t1_best_dist", Best_Dist, 64'h100);
    chk("t1_best_index", 64'(Best_Index), 64'd2);
    chk("t1_hit_any", 64'(Hit_Any), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_wp_hold", 64'(Write_Pixel), 64'd1);
      chk("t1_dist_hold", Best_Dist, 64'h100);
      chk("t1_idx_hold", 64'(Best_Index), 64'd2);
      chk("t1_no_adv", 64'(Pixel_Adv), 64'd0);
    end
    accept("t1");
    chk("t1_ri_idle", 64'(Read_Index), 64'd0);

    // Pixel 2: equal distances on 1 and 3, lower index wins.
    set_tbl(4'b1011, 64'h300, 64'h200, 64'h0, 64'h200);
    sweep_to_write("t2", cyc);
    chk("t2_best_dist", Best_Dist, 64'h200);
    chk("t2_best_index", 64'(Best_Index), 64'd1);
    chk("t2_hit_any", 64'(Hit_Any), 64'd1);
    accept("t2");

    // Pixel 3: no real hit; the FAR_DIST "hit" on index 0 must not count.
    set_tbl(4'b0001, FAR, 64'h0, 64'h0, 64'h0);
    sweep_to_write("t3", cyc);
    chk("t3_best_dist", Best_Dist, FAR);
    chk("t3_best_index", 64'(Best_Index), 64'd0);
    chk("t3_hit_any", 64'(Hit_Any), 64'd0);
    chk("t3_wp", 64'(Write_Pixel), 64'd1);
    accept("t3");

    // Abort in sweep cycle 2, the cycle index 0's hit is presented.
    set_tbl(4'b0001, 64'h50, 64'h0, 64'h0, 64'h0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    chk("t4_busy_c2", 64'(Busy), 64'd1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("t4_abort_idle", 64'(Busy), 64'd0);
    chk("t4_abort_ri", 64'(Read_Index), 64'd0);
    chk("t4_abort_dist", Best_Dist, FAR);
    chk("t4_abort_hit", 64'(Hit_Any), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t4_no_wp", 64'(Write_Pixel), 64'd0);
      chk("t4_no_adv", 64'(Pixel_Adv), 64'd0);
    end
    Start = 1'b1;
    Abort = 1'b1;
    step();
    Start = 1'b0;
    Abort = 1'b0;
    chk("t4_abort_start_idle", 64'(Busy), 64'd0);
    set_tbl(4'b1000, 64'h0, 64'h0, 64'h0, 64'h80);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("t4_restart_ri", 64'(Read_Index), 64'd0);
    chk("t4_restart_dist", Best_Dist, FAR);
    cyc = 0;
    while (!Write_Pixel && cyc < 30) begin
      step();
      cyc++;
    end
    chk("t4_write_cycle", 64'(cyc), 64'd6);
    chk("t4_best_dist", Best_Dist, 64'h80);
    chk("t4_best_index", 64'(Best_Index), 64'd3);
    accept("t4");

    // Asynchronous reset while waiting in WRITE.
    set_tbl(4'b0010, 64'h0, 64'h40, 64'h0, 64'h0);
    sweep_to_write("t5", cyc);
    chk("t5_pre_dist", Best_Dist, 64'h40);
    #2 Reset_n = 1'b0;
    #1;
    chk("t5_rst_wp", 64'(Write_Pixel), 64'd0);
    chk("t5_rst_busy", 64'(Busy), 64'd0);
    chk("t5_rst_dist", Best_Dist, FAR);
    chk("t5_rst_idx", 64'(Best_Index), 64'd0);
    chk("t5_rst_hit", 64'(Hit_Any), 64'd0);
    chk("t5_rst_ri", 64'(Read_Index), 64'd0);
    step();
    Reset_n = 1'b1;
    step();
    chk("t5_no_adv", 64'(Pixel_Adv), 64'd0);

    // Start and Write_Ready held high: back-to-back pixels every 8 cycles.
    set_tbl(4'b0000, 64'h0, 64'h0, 64'h0, 64'h0);
    Start       = 1'b1;
    Write_Ready = 1'b1;
    t      = 0;
    npulse = 0;
    while (npulse < 3 && t < 60) begin
      step();
      t++;
      if (Pixel_Adv) begin
        pt[npulse] = t;
        npulse++;
      end
    end
    Start       = 1'b0;
    Write_Ready = 1'b0;
    chk("t6_pulses", 64'(npulse), 64'd3);
    if (npulse == 3) begin
      chk("t6_gap1", 64'(pt[1] - pt[0]), 64'd8);
      chk("t6_gap2", 64'(pt[2] - pt[1]), 64'd8);
    end
    step();
    chk("t6_idle_after", 64'(Busy), 64'd0);
    chk("t6_adv_low", 64'(Pixel_Adv), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_sweep_scheduler.md
Name: ray_sweep_scheduler

Overview:
Sequences one pixel's ray through the shared sphere-register read port and the single collision_detection datapath. It sweeps sphere indices 0..N_SPHERES-1 in a pipelined fashion and keeps the nearest hit as a running minimum. It then hands the winning distance and index to the colour/write stage with a ready/valid handshake and advances the pixel counter. It replaces the hard-coded per-sphere state chain in the top level and scales with sphere count and read latency.

Parameters:
N_SPHERES, 4, number of spheres swept per pixel (>=1)
IDX_W, 2, width of sphere index (>= clog2(N_SPHERES), min 1)
DIST_W, 64, width of fixed-point distance
READ_LAT, 2, cycles from Read_Index driven to Collision/Curr_Dist valid (>=1)
FAR_DIST, 64'hefffffffffffffff, "no hit" sentinel distance

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Start  in  1  begin sweep for current pixel (sampled only in IDLE)
Abort  in  1  synchronous cancel (frame restart); highest priority after reset
Read_Index  out  IDX_W  sphere index to sphere register read port
Collision  in  1  datapath hit flag for index issued READ_LAT cycles earlier
Curr_Dist  in  DIST_W  datapath distance for that index
Best_Dist  out  DIST_W  running/final nearest distance
Best_Index  out  IDX_W  index of nearest sphere
Hit_Any  out  1  at least one accepted hit this pixel
Busy  out  1  high in any state but IDLE
Write_Pixel  out  1  valid: result ready for frame buffer write
Write_Ready  in  1  frame buffer accepts write
Pixel_Adv  out  1  one-cycle pulse after accepted write (advance WriteX/WriteY)

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Read_Index=0, Best_Dist=FAR_DIST, Best_Index=0, Hit_Any=0, Write_Pixel=0, Pixel_Adv=0, tag/valid pipe cleared.
- States: IDLE, SWEEP, DRAIN, WRITE.
- IDLE: Start=1 -> SWEEP; on that edge Best_Dist<=FAR_DIST, Best_Index<=0, Hit_Any<=0, issue counter<=0.
- SWEEP: Read_Index=issue counter, one new index per cycle; each pushes (valid=1, index) into a READ_LAT-deep tag pipe. After issuing N_SPHERES-1 -> DRAIN. Read_Index holds last value in DRAIN/WRITE and returns to 0 in IDLE.
- Compare: on every cycle the pipe output is valid, if Collision=1 and Curr_Dist < Best_Dist (unsigned, strict), then Best_Dist<=Curr_Dist, Best_Index<=tagged index, Hit_Any<=1. Ties keep the earlier (lower) index. Collision=0 or invalid slot: no update. Curr_Dist=FAR_DIST with Collision=1 is never accepted.
- DRAIN: leaves when the pipe is empty (last result consumed) -> WRITE. First SWEEP cycle = cycle 0; last compare at cycle N_SPHERES-1+READ_LAT; WRITE entered at cycle N_SPHERES+READ_LAT.
- WRITE: Write_Pixel=1; Best_* stable. On cycle with Write_Ready=1 -> IDLE, Pixel_Adv=1 for exactly the following cycle. Write_Ready low -> hold indefinitely.
- Start while Busy: ignored. Start held high: new sweep begins the cycle after return to IDLE (the IDLE cycle coincides with Pixel_Adv).
- Abort=1 in any state: next state IDLE, pipe cleared, Write_Pixel=0, no Pixel_Adv; Best_* keep current values. Abort in IDLE with Start=1: stay IDLE.
- Reset mid-sweep/mid-write: immediate return to reset values; no partial write.
- N_SPHERES=1: SWEEP lasts one cycle.

Test Plan:
- Four spheres, Collision only idx2 with Curr_Dist=0x100 -> Best_Index=2, Best_Dist=0x100, Hit_Any=1; Write_Pixel rises at cycle 6 (N=4, READ_LAT=2).
- Hits idx0=0x300, idx1=0x200, idx3=0x200 -> Best_Index=1, Best_Dist=0x200 (tie keeps lower index).
- No collisions -> Best_Dist=FAR_DIST, Best_Index=0, Hit_Any=0, Write_Pixel still asserted, one Pixel_Adv after accept.
- Write_Ready low 5 cycles in WRITE -> Write_Pixel held, Best_* stable, Pixel_Adv single pulse one cycle after Write_Ready=1.
- Abort in SWEEP cycle 2 -> IDLE next cycle, no Write_Pixel, no Pixel_Adv; subsequent Start sweeps cleanly from index 0 with Best_Dist reset.
- Reset_n pulsed low during WRITE -> all outputs at reset values immediately, asynchronously; Start held high across 3 pixels -> 3 Pixel_Adv pulses spaced N_SPHERES+READ_LAT+2 cycles apart with Write_Ready tied high.
